// File: rtl/spi_lcd_master.sv
// SPI mode-0 master for the 160x80 LCD PMOD: one command byte, 0-4 parameter
// bytes and an optional single-byte readback, with D/C and chip-select control.
module spi_lcd_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_start_cmd,
    input  logic [2:0] spi_mode,
    input  logic [7:0] cmd_spi_cmd,
    input  logic [7:0] cmd_spi_data1,
    input  logic [7:0] cmd_spi_data2,
    input  logic [7:0] cmd_spi_data3,
    input  logic [7:0] cmd_spi_data4,
    input  logic [3:0] cmd_spi_data_num,
    input  logic       spi_read_mode,
    input  logic       lcd_miso,
    output logic       spi_busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic [7:0] rd_data,
    output logic       rd_valid
);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {IDLE, SHIFT, READ, HOLD, GAP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [2:0]       byte_reg, byte_next;
    logic [2:0]       last_reg, last_next;
    logic             read_reg, read_next;
    logic [7:0]       rx_reg, rx_next;
    logic             busy_reg, busy_next;
    logic             sclk_reg, sclk_next;
    logic             mosi_reg, mosi_next;
    logic             cs_n_reg, cs_n_next;
    logic             dc_reg, dc_next;
    logic [7:0]       rd_data_reg, rd_data_next;
    logic             rd_valid_reg, rd_valid_next;

    logic             load_tx;
    logic [7:0]       tx_in  [0:4];
    logic [7:0]       tx_reg [0:4];
    logic [7:0]       cur_byte;
    logic [2:0]       byte_inc;
    logic             div_end;
    logic             mode_data;

    assign tx_in[0] = cmd_spi_cmd;
    assign tx_in[1] = cmd_spi_data1;
    assign tx_in[2] = cmd_spi_data2;
    assign tx_in[3] = cmd_spi_data3;
    assign tx_in[4] = cmd_spi_data4;

    // Frame bytes are captured once at start so later input changes cannot leak in.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_tx
            always_ff @(posedge clk) begin
                if (rst) begin
                    tx_reg[gi] <= 8'h00;
                end else if (load_tx) begin
                    tx_reg[gi] <= tx_in[gi];
                end
            end
        end
    endgenerate

    assign cur_byte  = tx_reg[byte_reg];
    assign byte_inc  = byte_reg + 3'd1;
    assign div_end   = (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign mode_data = (spi_mode == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= 3'd0;
            byte_reg     <= 3'd0;
            last_reg     <= 3'd0;
            read_reg     <= 1'b0;
            rx_reg       <= 8'h00;
            busy_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            dc_reg       <= 1'b0;
            rd_data_reg  <= 8'h00;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            last_reg     <= last_next;
            read_reg     <= read_next;
            rx_reg       <= rx_next;
            busy_reg     <= busy_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            cs_n_reg     <= cs_n_next;
            dc_reg       <= dc_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        last_next     = last_reg;
        read_next     = read_reg;
        rx_next       = rx_reg;
        busy_next     = busy_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        cs_n_next     = cs_n_reg;
        dc_next       = dc_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        load_tx       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (spi_start_cmd) begin
                    load_tx    = 1'b1;
                    last_next  = mode_data ? ((cmd_spi_data_num > 4'd4) ? 3'd4 : cmd_spi_data_num[2:0])
                                           : 3'd0;
                    read_next  = !mode_data && spi_read_mode;
                    state_next = SHIFT;
                    cnt_next   = '0;
                    bit_next   = 3'd0;
                    byte_next  = 3'd0;
                    sclk_next  = 1'b0;
                    mosi_next  = cmd_spi_cmd[7];
                    dc_next    = 1'b0;
                    cs_n_next  = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg != 3'd7) begin
                            bit_next  = bit_reg + 3'd1;
                            mosi_next = cur_byte[3'(3'd6 - bit_reg)];
                        end else if (byte_reg != last_reg) begin
                            byte_next = byte_inc;
                            bit_next  = 3'd0;
                            mosi_next = tx_reg[byte_inc][7];
                            dc_next   = 1'b1;
                        end else begin
                            bit_next   = 3'd0;
                            mosi_next  = 1'b0;
                            dc_next    = 1'b0;
                            state_next = read_reg ? READ : HOLD;
                        end
                    end
                end
            end
            READ: begin
                if (!div_end) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                        rx_next   = {rx_reg[6:0], lcd_miso};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg != 3'd7) begin
                            bit_next = bit_reg + 3'd1;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (!div_end) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    cnt_next   = '0;
                    state_next = GAP;
                    cs_n_next  = 1'b1;
                    mosi_next  = 1'b0;
                    dc_next    = 1'b0;
                    if (read_reg) begin
                        rd_data_next  = rx_reg;
                        rd_valid_next = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_reg == CNT_W'(CS_GAP - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign spi_busy = busy_reg;
    assign lcd_sclk = sclk_reg;
    assign lcd_mosi = mosi_reg;
    assign lcd_cs_n = cs_n_reg;
    assign lcd_dc   = dc_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_spi_lcd_master.sv
// Directed bench for spi_lcd_master: a pin monitor records each frame and the
// main sequence compares the recording against hand-computed values.
module tb_spi_lcd_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_start_cmd = 1'b0;
    logic [2:0] spi_mode = 3'd0;
    logic [7:0] cmd_spi_cmd = 8'h00;
    logic [7:0] cmd_spi_data1 = 8'h00;
    logic [7:0] cmd_spi_data2 = 8'h00;
    logic [7:0] cmd_spi_data3 = 8'h00;
    logic [7:0] cmd_spi_data4 = 8'h00;
    logic [3:0] cmd_spi_data_num = 4'd0;
    logic       spi_read_mode = 1'b0;
    logic       lcd_miso = 1'b0;
    logic       spi_busy, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc, rd_valid;
    logic [7:0] rd_data;

    int checks = 0;
    int failures = 0;

    spi_lcd_master #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst), .spi_start_cmd(spi_start_cmd), .spi_mode(spi_mode),
        .cmd_spi_cmd(cmd_spi_cmd), .cmd_spi_data1(cmd_spi_data1), .cmd_spi_data2(cmd_spi_data2),
        .cmd_spi_data3(cmd_spi_data3), .cmd_spi_data4(cmd_spi_data4),
        .cmd_spi_data_num(cmd_spi_data_num), .spi_read_mode(spi_read_mode), .lcd_miso(lcd_miso),
        .spi_busy(spi_busy), .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi), .lcd_cs_n(lcd_cs_n),
        .lcd_dc(lcd_dc), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // Per-frame recording, cleared when spi_busy rises.
    logic [63:0] cap_bits = '0;
    logic [63:0] cap_dc = '0;
    logic [7:0]  rd_pat = 8'h00;
    int rises = 0, busy_cnt = 0, cs_low_cnt = 0, cs_falls = 0, mosi_bad = 0;
    int rdv_cnt = 0, rdv_at_gap = 0, frames = 0, idle_cnt = 0, last_idle = 0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs_n = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (spi_busy && !prev_busy) begin
            frames++;
            last_idle = idle_cnt;
            cap_bits = '0; cap_dc = '0;
            rises = 0; busy_cnt = 0; cs_low_cnt = 0; cs_falls = 0;
            mosi_bad = 0; rdv_cnt = 0; rdv_at_gap = 0;
        end
        if (!spi_busy) idle_cnt = prev_busy ? 1 : idle_cnt + 1;
        else busy_cnt++;
        if (!lcd_cs_n) cs_low_cnt++;
        if (!lcd_cs_n && prev_cs_n) cs_falls++;
        if (lcd_sclk && lcd_mosi != prev_mosi) mosi_bad++;
        if (lcd_sclk && !prev_sclk) begin
            rises++;
            cap_bits = {cap_bits[62:0], lcd_mosi};
            cap_dc   = {cap_dc[62:0], lcd_dc};
        end
        if (rd_valid) begin
            rdv_cnt++;
            if (lcd_cs_n && !prev_cs_n) rdv_at_gap++;
        end
        lcd_miso = (rises >= 8 && rises < 16) ? rd_pat[15 - rises] : 1'b0;
        prev_sclk = lcd_sclk; prev_mosi = lcd_mosi; prev_cs_n = lcd_cs_n; prev_busy = spi_busy;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input logic [2:0] mode, input logic [7:0] cmd, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] d4,
                              input logic [3:0] num, input logic rd);
        spi_mode = mode; cmd_spi_cmd = cmd;
        cmd_spi_data1 = d1; cmd_spi_data2 = d2; cmd_spi_data3 = d3; cmd_spi_data4 = d4;
        cmd_spi_data_num = num; spi_read_mode = rd;
    endtask

    task automatic pulse_start();
        spi_start_cmd = 1'b1;
        @(negedge clk);
        spi_start_cmd = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int t = 0;
        while (spi_busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_done"}, {63'd0, spi_busy}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pins"}, {58'd0, spi_busy, lcd_sclk, lcd_mosi, lcd_cs_n, lcd_dc, rd_valid},
                 64'b000100);
        check_eq({tag, "_rd_data"}, {56'd0, rd_data}, 64'd0);
    endtask

    initial begin
        int f0;
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        $display("txn reset: power-on reset state checked");

        // Reset in the middle of a long frame
        set_inputs(3'd1, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 4'd4, 1'b0);
        pulse_start();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst_after");
        $display("txn reset: mid-frame reset checked");

        set_inputs(3'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        pulse_start();
        wait_frame("cmd01");
        check_eq("cmd01_bits", cap_bits, 64'h01);
        check_eq("cmd01_rises", rises, 8);
        check_eq("cmd01_dc", cap_dc, 64'h0);
        check_eq("cmd01_busy", busy_cnt, 38);
        check_eq("cmd01_cslow", cs_low_cnt, 34);
        $display("txn mode0 cmd=01 busy=%0d cs_low=%0d bits=%0h", busy_cnt, cs_low_cnt, cap_bits);

        set_inputs(3'd1, 8'h2A, 8'h00, 8'h1A, 8'h00, 8'h6A, 4'd4, 1'b0);
        pulse_start();
        wait_frame("caset");
        check_eq("caset_bits", cap_bits, 64'h2A001A006A);
        check_eq("caset_dc", cap_dc, 64'h00FFFFFFFF);
        check_eq("caset_busy", busy_cnt, 166);
        check_eq("caset_cslow", cs_low_cnt, 162);
        check_eq("caset_csfalls", cs_falls, 1);
        check_eq("caset_mosi_stable", mosi_bad, 0);
        $display("txn mode1 cmd=2A busy=%0d bits=%0h", busy_cnt, cap_bits);

        set_inputs(3'd1, 8'h3C, 8'h99, 8'h99, 8'h99, 8'h99, 4'd0, 1'b0);
        pulse_start();
        wait_frame("num0");
        check_eq("num0_bits", cap_bits, 64'h3C);
        check_eq("num0_busy", busy_cnt, 38);
        $display("txn mode1 num=0 busy=%0d bits=%0h", busy_cnt, cap_bits);

        set_inputs(3'd1, 8'h2C, 8'h11, 8'h22, 8'h33, 8'h44, 4'd9, 1'b0);
        pulse_start();
        wait_frame("num9");
        check_eq("num9_bits", cap_bits, 64'h2C11223344);
        check_eq("num9_busy", busy_cnt, 166);
        $display("txn mode1 num=9 busy=%0d bits=%0h", busy_cnt, cap_bits);

        set_inputs(3'd5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 4'd4, 1'b0);
        pulse_start();
        wait_frame("mode5");
        check_eq("mode5_bits", cap_bits, 64'h5A);
        check_eq("mode5_busy", busy_cnt, 38);
        $display("txn mode5 busy=%0d bits=%0h", busy_cnt, cap_bits);

        rd_pat = 8'hA5;
        set_inputs(3'd1, 8'h36, 8'h48, 8'h00, 8'h00, 8'h00, 4'd1, 1'b1);
        pulse_start();
        wait_frame("m1rd");
        check_eq("m1rd_bits", cap_bits, 64'h3648);
        check_eq("m1rd_dc", cap_dc, 64'h00FF);
        check_eq("m1rd_busy", busy_cnt, 70);
        check_eq("m1rd_rdv", rdv_cnt, 0);
        check_eq("m1rd_rd_data", {56'd0, rd_data}, 64'h00);
        $display("txn mode1 read ignored busy=%0d bits=%0h", busy_cnt, cap_bits);

        set_inputs(3'd0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1);
        pulse_start();
        wait_frame("read");
        check_eq("read_bits", cap_bits, 64'h0400);
        check_eq("read_rises", rises, 16);
        check_eq("read_dc", cap_dc, 64'h0);
        check_eq("read_busy", busy_cnt, 70);
        check_eq("read_rd_data", {56'd0, rd_data}, 64'hA5);
        check_eq("read_rdv_cnt", rdv_cnt, 1);
        check_eq("read_rdv_gap", rdv_at_gap, 1);
        $display("txn read cmd=04 rd_data=%0h busy=%0d", rd_data, busy_cnt);

        rd_pat = 8'h3C;
        set_inputs(3'd0, 8'hE7, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1);
        pulse_start();
        wait_frame("read2");
        check_eq("read2_rd_data", {56'd0, rd_data}, 64'h3C);
        $display("txn read cmd=E7 rd_data=%0h", rd_data);

        // Start pulse and input changes while busy must be ignored
        f0 = frames;
        set_inputs(3'd0, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        pulse_start();
        repeat (10) @(negedge clk);
        set_inputs(3'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd4, 1'b1);
        pulse_start();
        wait_frame("drop");
        check_eq("drop_bits", cap_bits, 64'h11);
        check_eq("drop_busy", busy_cnt, 38);
        repeat (40) @(negedge clk);
        check_eq("drop_frames", frames - f0, 1);
        $display("txn busy-start dropped frames=%0d", frames - f0);

        // Start held high retriggers after exactly one idle cycle
        f0 = frames;
        set_inputs(3'd0, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0);
        spi_start_cmd = 1'b1;
        t = 0;
        while (!spi_busy && t < 10) begin @(negedge clk); t++; end
        while (spi_busy && t < 200) begin @(negedge clk); t++; end
        while (!spi_busy && t < 210) begin @(negedge clk); t++; end
        spi_start_cmd = 1'b0;
        @(negedge clk);
        check_eq("held_idle", last_idle, 1);
        wait_frame("held");
        check_eq("held_bits", cap_bits, 64'h22);
        check_eq("held_busy", busy_cnt, 38);
        check_eq("held_frames", frames - f0, 2);
        $display("txn held start idle=%0d frames=%0d", last_idle, frames - f0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
